// File: rtl/reg_writeback_if.sv
// Register-file / write-back bundle between the pipeline front end
// (Decode/Execute/Memory side, master) and the write-back stage (slave).
// The master drives the retiring instruction and the Decode read
// addresses; the slave returns read data, selected destinations, the
// sticky halt flag and the retired-instruction count.
interface reg_writeback_if #(
  parameter int DW    = 64,
  parameter int CNT_W = 32
);
  logic             inst_valid;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             Cnd;
  logic [DW-1:0]    valE;
  logic [DW-1:0]    valM;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [DW-1:0]    valA;
  logic [DW-1:0]    valB;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output inst_valid, icode, ifun, rA, rB, Cnd, valE, valM, srcA, srcB,
    input  valA, valB, dstE, dstM, halted, retired
  );

  modport slave (
    input  inst_valid, icode, ifun, rA, rB, Cnd, valE, valM, srcA, srcB,
    output valA, valB, dstE, dstM, halted, retired
  );
endinterface

// File: rtl/reg_writeback.sv
// SEQ write-back stage plus the 15-entry architectural register file.
// Selects dstE/dstM from the retiring instruction, commits valE/valM on
// the rising edge (valM wins when both target the same register), serves
// the two combinational Decode read ports, and keeps the sticky halt flag
// and a wrapping retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to forward the in-flight commit
// onto valA/valB within the same cycle; left undefined, reads return the
// stored register contents only.
// The DW/CNT_W parameters must match those of the connected interface.
module reg_writeback #(
  parameter int DW    = 64,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  reg_writeback_if.slave wb
);

  // Y86-64 instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register identifiers
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DW-1:0]    r_regs [0:14];
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic [3:0]       w_dst_e;
  logic [3:0]       w_dst_m;
  logic             w_commit;
  logic [DW-1:0]    w_val_a;
  logic [DW-1:0]    w_val_b;
  logic             w_unused_ifun;

  // ifun carries no meaning for destination selection in this stage
  assign w_unused_ifun = ^wb.ifun;

  // An instruction commits only while the machine is still running
  assign w_commit = wb.inst_valid & ~r_halted;

  // Stored-state read; RNONE never maps to storage and reads as zero
  function automatic logic [DW-1:0] f_read(input logic [3:0] src);
    logic [DW-1:0] v;
    if (src == RNONE) begin
      v = {DW{1'b0}};
    end else begin
      v = r_regs[src];
    end
    return v;
  endfunction

  // Same-cycle forwarding of the in-flight commit, M side first so the
  // forwarded value agrees with what the register will hold after the edge
  function automatic logic [DW-1:0] f_fwd(input logic [3:0] src,
                                          input logic [3:0] dst_e,
                                          input logic [3:0] dst_m,
                                          input logic       commit);
    logic [DW-1:0] v;
    if (commit && (src != RNONE) && (src == dst_m)) begin
      v = wb.valM;
    end else if (commit && (src != RNONE) && (src == dst_e)) begin
      v = wb.valE;
    end else begin
      v = f_read(src);
    end
    return v;
  endfunction

  // Destination selection from icode (and Cnd for conditional moves)
  always_comb begin
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (wb.icode)
      IRRMOVQ: begin
        w_dst_e = wb.Cnd ? wb.rB : RNONE;
        w_dst_m = RNONE;
      end
      IIRMOVQ, IOPQ: begin
        w_dst_e = wb.rB;
        w_dst_m = RNONE;
      end
      ICALL, IRET, IPUSHQ: begin
        w_dst_e = RRSP;
        w_dst_m = RNONE;
      end
      IPOPQ: begin
        w_dst_e = RRSP;
        w_dst_m = wb.rA;
      end
      IMRMOVQ: begin
        w_dst_e = RNONE;
        w_dst_m = wb.rA;
      end
      IHALT, INOP, IRMMOVQ, IJXX: begin
        w_dst_e = RNONE;
        w_dst_m = RNONE;
      end
      default: begin
        w_dst_e = RNONE;
        w_dst_m = RNONE;
      end
    endcase
  end

  // Decode read ports, optionally forwarding the commit in flight
  always_comb begin
    w_val_a = {DW{1'b0}};
    w_val_b = {DW{1'b0}};
`ifdef WB_BYPASS_EN
    w_val_a = f_fwd(wb.srcA, w_dst_e, w_dst_m, w_commit);
    w_val_b = f_fwd(wb.srcB, w_dst_e, w_dst_m, w_commit);
`else
    w_val_a = f_read(wb.srcA);
    w_val_b = f_read(wb.srcB);
`endif
  end

  // Architectural state: register file, halt flag and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= {DW{1'b0}};
      end
      r_halted  <= 1'b0;
      r_retired <= {CNT_W{1'b0}};
    end else if (w_commit) begin
      if (w_dst_e != RNONE) begin
        r_regs[w_dst_e] <= wb.valE;
      end
      // Issued after the E write so that M wins on a shared destination
      if (w_dst_m != RNONE) begin
        r_regs[w_dst_m] <= wb.valM;
      end
      r_retired <= r_retired + CNT_ONE;
      if (wb.icode == IHALT) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign wb.dstE    = w_dst_e;
  assign wb.dstM    = w_dst_m;
  assign wb.valA    = w_val_a;
  assign wb.valB    = w_val_b;
  assign wb.halted  = r_halted;
  assign wb.retired = r_retired;

  // The f_fwd helper is only referenced when forwarding is built in
`ifndef WB_BYPASS_EN
  logic [DW-1:0] w_unused_fwd;
  assign w_unused_fwd = f_fwd(4'hF, 4'hF, 4'hF, 1'b0);
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a table of retiring instructions
// with hand-written expected destinations, a small architectural model for
// read-port values, and a scoreboard queue of expected halted/retired
// values checked after each clock edge. A narrow counter makes the
// wrap-around reachable in a short run.
module tb_reg_writeback;

  localparam int DW    = 64;
  localparam int CNT_W = 4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] NONE    = 4'hF;

  typedef struct {
    logic          iv;
    logic [3:0]    icode;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic          cnd;
    logic [DW-1:0] vale;
    logic [DW-1:0] valm;
    logic [3:0]    srca;
    logic [3:0]    srcb;
    logic [3:0]    exp_dste;
    logic [3:0]    exp_dstm;
  } vec_t;

  typedef struct {
    logic             halted;
    logic [CNT_W-1:0] retired;
  } sb_t;

  logic clk;
  logic rst;

  reg_writeback_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  reg_writeback #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [DW-1:0]    m_regs [0:14];
  logic             m_halted;
  logic [CNT_W-1:0] m_retired;
  sb_t              sb_q [$];
  vec_t             tbl [20];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [3:0] src, input vec_t v);
    logic [DW-1:0] r;
    r = (src == NONE) ? {DW{1'b0}} : m_regs[src];
`ifdef WB_BYPASS_EN
    if (v.iv && !m_halted && src != NONE) begin
      if (src == v.exp_dstm) r = v.valm;
      else if (src == v.exp_dste) r = v.vale;
    end
`endif
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.inst_valid = v.iv;
    bus.icode      = v.icode;
    bus.ifun       = 4'h0;
    bus.rA         = v.ra;
    bus.rB         = v.rb;
    bus.Cnd        = v.cnd;
    bus.valE       = v.vale;
    bus.valM       = v.valm;
    bus.srcA       = v.srca;
    bus.srcB       = v.srcb;
  endtask

  // Drive one vector, check combinational outputs, then the registered ones
  task automatic apply(input int idx, input vec_t v);
    sb_t e;
    sb_t g;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("dstE[%0d]", idx), {60'd0, bus.dstE}, {60'd0, v.exp_dste});
    chk($sformatf("dstM[%0d]", idx), {60'd0, bus.dstM}, {60'd0, v.exp_dstm});
    chk($sformatf("valA[%0d]", idx), bus.valA, m_read(v.srca, v));
    chk($sformatf("valB[%0d]", idx), bus.valB, m_read(v.srcb, v));
    if (v.iv && !m_halted) begin
      if (v.exp_dste != NONE) m_regs[v.exp_dste] = v.vale;
      if (v.exp_dstm != NONE) m_regs[v.exp_dstm] = v.valm;
      m_retired = m_retired + 4'd1;
      if (v.icode == IHALT) m_halted = 1'b1;
    end
    e.halted  = m_halted;
    e.retired = m_retired;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk($sformatf("halted[%0d]", idx), {63'd0, bus.halted}, {63'd0, g.halted});
    chk($sformatf("retired[%0d]", idx), {60'd0, bus.retired}, {60'd0, g.retired});
  endtask

  task automatic do_reset_and_check(input string tag);
    vec_t v;
    @(negedge clk);
    rst = 1'b1;
    v = '{1'b1, IIRMOVQ, 4'hF, 4'h9, 1'b0, 64'h5, 64'h0, NONE, NONE, 4'h9, NONE};
    drive(v);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_halted  = 1'b0;
    m_retired = 4'd0;
    #1;
    chk({tag, "_halted"}, {63'd0, bus.halted}, 64'd0);
    chk({tag, "_retired"}, {60'd0, bus.retired}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      bus.srcA = i[3:0];
      bus.srcB = 4'(14 - i);
      #1;
      chk($sformatf("%s_valA[%0d]", tag, i), bus.valA, 64'd0);
      chk($sformatf("%s_valB[%0d]", tag, 14 - i), bus.valB, 64'd0);
    end
  endtask

  initial begin
    vec_t nop_v;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    nop_v = '{1'b0, INOP, NONE, NONE, 1'b0, 64'h0, 64'h0, NONE, NONE, NONE, NONE};
    drive(nop_v);

    //           iv    icode    rA    rB    Cnd   valE        valM      srcA  srcB  dstE  dstM
    tbl[0]  = '{1'b1, IIRMOVQ, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0,   4'h3, NONE, 4'h3, NONE};
    tbl[1]  = '{1'b1, INOP,    4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   4'h3, NONE, NONE, NONE};
    tbl[2]  = '{1'b1, IRRMOVQ, 4'h1, 4'h5, 1'b0, 64'hAA,   64'h0,   4'h5, NONE, NONE, NONE};
    tbl[3]  = '{1'b1, IRRMOVQ, 4'h1, 4'h5, 1'b1, 64'hAA,   64'h0,   4'h5, 4'h3, 4'h5, NONE};
    tbl[4]  = '{1'b1, INOP,    4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   4'h5, 4'h3, NONE, NONE};
    tbl[5]  = '{1'b1, IPOPQ,   4'h4, 4'hF, 1'b0, 64'h100,  64'h200, 4'h4, NONE, 4'h4, 4'h4};
    tbl[6]  = '{1'b1, IPOPQ,   4'h2, 4'hF, 1'b0, 64'h100,  64'h200, 4'h4, 4'h2, 4'h4, 4'h2};
    tbl[7]  = '{1'b1, INOP,    4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   4'h2, 4'h4, NONE, NONE};
    tbl[8]  = '{1'b1, IOPQ,    4'h0, 4'h6, 1'b0, 64'h55,   64'h0,   NONE, 4'h6, 4'h6, NONE};
    tbl[9]  = '{1'b1, IMRMOVQ, 4'h7, 4'h1, 1'b0, 64'h99,   64'h77,  4'h7, 4'h6, NONE, 4'h7};
    tbl[10] = '{1'b1, ICALL,   4'hF, 4'hF, 1'b0, 64'h300,  64'h0,   4'h4, 4'h7, 4'h4, NONE};
    tbl[11] = '{1'b1, IRET,    4'hF, 4'hF, 1'b0, 64'h308,  64'h0,   4'h4, NONE, 4'h4, NONE};
    tbl[12] = '{1'b1, IPUSHQ,  4'h3, 4'hF, 1'b0, 64'h2F8,  64'h0,   4'h4, 4'h3, 4'h4, NONE};
    tbl[13] = '{1'b1, IRMMOVQ, 4'h1, 4'h2, 1'b0, 64'hDEAD, 64'h0,   4'h1, 4'h2, NONE, NONE};
    tbl[14] = '{1'b1, IJXX,    4'hF, 4'hF, 1'b1, 64'h40,   64'h0,   NONE, NONE, NONE, NONE};
    tbl[15] = '{1'b1, 4'hC,    4'h3, 4'h3, 1'b1, 64'hBAD,  64'hBAD, 4'h3, NONE, NONE, NONE};
    tbl[16] = '{1'b0, IIRMOVQ, 4'hF, 4'h8, 1'b0, 64'h1,    64'h0,   4'h8, NONE, 4'h8, NONE};
    tbl[17] = '{1'b1, IHALT,   4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   4'h8, 4'h1, NONE, NONE};
    tbl[18] = '{1'b1, IIRMOVQ, 4'hF, 4'h1, 1'b0, 64'h7,    64'h0,   4'h1, NONE, 4'h1, NONE};
    tbl[19] = '{1'b1, INOP,    4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   4'h1, 4'h4, NONE, NONE};

    // Reset (with an instruction colliding on the reset edge)
    do_reset_and_check("reset0");

    // Main table
    for (int i = 0; i < 20; i++) apply(i, tbl[i]);

    // Reset clears halted and discards the colliding instruction
    do_reset_and_check("reset1");

    // Counter wrap: 20 committed NOPs through a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      nop_v = '{1'b1, INOP, NONE, NONE, 1'b0, 64'h0, 64'h0, 4'(i % 15), NONE, NONE, NONE};
      apply(100 + i, nop_v);
    end

    // Same-cycle read of a register being written
    nop_v = '{1'b1, IOPQ, 4'h0, 4'h6, 1'b0, 64'h55, 64'h0, NONE, 4'h6, 4'h6, NONE};
    apply(200, nop_v);
    nop_v = '{1'b1, INOP, NONE, NONE, 1'b0, 64'h0, 64'h0, NONE, 4'h6, NONE, NONE};
    apply(201, nop_v);
    chk("reg6_after_opq", bus.valB, 64'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
